gpio_bank: RTL and testbench

- Parametrised successor to the single write-only GPIO output register in the SOC memory-mapped page.
- Provides per-pin direction, input synchronisation, atomic set/clear/toggle and edge-detect interrupt status.
- Sits on the processor's native memory bus (mem_* signals) behind an SOC address decode that drives `sel`.
- Read data is registered with 1-cycle latency, so it drops into the same mem_rdata mux as RAM.

---
 rtl/gpio_bank.sv | 121 ++++++++++++
 tb/tb_gpio_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: direction, synchronised inputs, atomic SET/CLR/TOG
// on OUT, and rise/fall edge-detect STATUS with W1C and level irq.
module gpio_bank #(
    parameter int unsigned      NPINS       = 32,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [NPINS-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sel,
    input  logic [3:0]       mem_wordoff,
    input  logic             mem_rstrb,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    output logic [31:0]      mem_rdata,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [3:0] OFF_OUT     = 4'd0;
    localparam logic [3:0] OFF_DIR     = 4'd1;
    localparam logic [3:0] OFF_IN      = 4'd2;
    localparam logic [3:0] OFF_SET     = 4'd3;
    localparam logic [3:0] OFF_CLR     = 4'd4;
    localparam logic [3:0] OFF_TOG     = 4'd5;
    localparam logic [3:0] OFF_RISE_EN = 4'd6;
    localparam logic [3:0] OFF_FALL_EN = 4'd7;
    localparam logic [3:0] OFF_STATUS  = 4'd8;

    logic [NPINS-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q, prev_q;
    logic [NPINS-1:0] out_d, dir_d, rise_en_d, fall_en_d, status_d;
    logic [NPINS-1:0] sync_q [SYNC_STAGES];
    logic [NPINS-1:0] s_last, rise, fall, w1c;
    logic [NPINS-1:0] lane_mask, wd_pins;
    logic [31:0]      byte_mask, wd_masked, rd_val;
    logic             wr_en, rd_en;

    assign wr_en     = sel & (|mem_wmask);
    assign rd_en     = sel & mem_rstrb;
    assign byte_mask = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}},
                        {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
    assign wd_masked = mem_wdata & byte_mask;
    assign lane_mask = byte_mask[NPINS-1:0];
    assign wd_pins   = wd_masked[NPINS-1:0];

    assign s_last = sync_q[SYNC_STAGES-1];
    assign rise   = s_last & ~prev_q;
    assign fall   = ~s_last & prev_q;

    // Masked lanes contribute zero, so SET/CLR/TOG/W1C need no separate lane handling.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr_en) begin
            case (mem_wordoff)
                OFF_OUT:     out_d     = (out_q & ~lane_mask) | wd_pins;
                OFF_DIR:     dir_d     = (dir_q & ~lane_mask) | wd_pins;
                OFF_SET:     out_d     = out_q | wd_pins;
                OFF_CLR:     out_d     = out_q & ~wd_pins;
                OFF_TOG:     out_d     = out_q ^ wd_pins;
                OFF_RISE_EN: rise_en_d = (rise_en_q & ~lane_mask) | wd_pins;
                OFF_FALL_EN: fall_en_d = (fall_en_q & ~lane_mask) | wd_pins;
                OFF_STATUS:  w1c       = wd_pins;
                default:     ;
            endcase
        end
        status_d = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        rd_val = '0;
        case (mem_wordoff)
            OFF_OUT:     rd_val = 32'(out_q);
            OFF_DIR:     rd_val = 32'(dir_q);
            OFF_IN:      rd_val = 32'(s_last);
            OFF_RISE_EN: rd_val = 32'(rise_en_q);
            OFF_FALL_EN: rd_val = 32'(fall_en_q);
            OFF_STATUS:  rd_val = 32'(status_q);
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q     <= OUT_RESET;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            mem_rdata <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= s_last;
            sync_q[0] <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            if (rd_en) begin
                mem_rdata <= rd_val;
            end
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: table-driven register vectors, a read
// scoreboard, and hand sequences for sync latency, W1C collision and async reset.
module tb_gpio_bank;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel, sel8;
    logic [3:0]  mem_wordoff;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata, rdata8;
    logic [31:0] gpio_in;
    logic [7:0]  gpio_in8;
    logic [31:0] gpio_out, gpio_oe;
    logic [7:0]  out8, oe8;
    logic        irq, irq8;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [3:0]  off;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [3:0]  roff;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        bit          d8;
        string       name;
    } sb_t;

    vec_t vecs [15];
    sb_t  sbq [$];

    gpio_bank u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .sel         (sel),
        .mem_wordoff (mem_wordoff),
        .mem_rstrb   (mem_rstrb),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_rdata   (mem_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    gpio_bank #(.NPINS(8)) u_dut8 (
        .clk         (clk),
        .resetn      (resetn),
        .sel         (sel8),
        .mem_wordoff (mem_wordoff),
        .mem_rstrb   (mem_rstrb),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_rdata   (rdata8),
        .gpio_in     (gpio_in8),
        .gpio_out    (out8),
        .gpio_oe     (oe8),
        .irq         (irq8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Read data is compared one edge after the strobe is sampled.
    always @(posedge clk) begin
        if ((sel || sel8) && mem_rstrb) begin
            #1;
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL sb_underflow: got read with no expected entry");
            end else begin
                sb_t it;
                it = sbq.pop_front();
                chk(it.name, it.d8 ? rdata8 : mem_rdata, it.exp);
            end
        end
    end

    task automatic idle();
        sel = 1'b0; sel8 = 1'b0; mem_rstrb = 1'b0; mem_wmask = 4'h0;
        mem_wordoff = 4'h0; mem_wdata = '0;
    endtask

    task automatic wr(input bit d8, input logic [3:0] off, input logic [31:0] data,
                      input logic [3:0] mask);
        sel = !d8; sel8 = d8; mem_rstrb = 1'b0;
        mem_wordoff = off; mem_wdata = data; mem_wmask = mask;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input bit d8, input logic [3:0] off, input logic [31:0] exp,
                      input string name);
        sb_t it;
        it.exp = exp; it.d8 = d8; it.name = name;
        sbq.push_back(it);
        sel = !d8; sel8 = d8; mem_rstrb = 1'b1;
        mem_wordoff = off; mem_wmask = 4'h0; mem_wdata = '0;
        @(negedge clk);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'd0, 32'h0000_00F0, 4'hF, 4'd0, 32'h0000_00F0, 32'h0000_00F0};
        vecs[1]  = '{4'd3, 32'h0000_000F, 4'hF, 4'd0, 32'h0000_00FF, 32'h0000_00FF};
        vecs[2]  = '{4'd4, 32'h0000_0030, 4'hF, 4'd0, 32'h0000_00CF, 32'h0000_00CF};
        vecs[3]  = '{4'd5, 32'h0000_0081, 4'hF, 4'd0, 32'h0000_004E, 32'h0000_004E};
        vecs[4]  = '{4'd3, 32'h0000_0000, 4'hF, 4'd3, 32'h0000_0000, 32'h0000_004E};
        vecs[5]  = '{4'd4, 32'h0000_0000, 4'hF, 4'd4, 32'h0000_0000, 32'h0000_004E};
        vecs[6]  = '{4'd5, 32'h0000_0000, 4'hF, 4'd5, 32'h0000_0000, 32'h0000_004E};
        vecs[7]  = '{4'd0, 32'h1122_3344, 4'hF, 4'd0, 32'h1122_3344, 32'h1122_3344};
        vecs[8]  = '{4'd0, 32'hAABB_CCDD, 4'h5, 4'd0, 32'h11BB_33DD, 32'h11BB_33DD};
        vecs[9]  = '{4'd3, 32'hFFFF_FFFF, 4'h2, 4'd0, 32'h11BB_FFDD, 32'h11BB_FFDD};
        vecs[10] = '{4'd1, 32'h0000_FFFF, 4'hF, 4'd1, 32'h0000_FFFF, 32'h11BB_FFDD};
        vecs[11] = '{4'd6, 32'h0000_0008, 4'hF, 4'd6, 32'h0000_0008, 32'h11BB_FFDD};
        vecs[12] = '{4'd7, 32'h0000_0020, 4'hF, 4'd7, 32'h0000_0020, 32'h11BB_FFDD};
        vecs[13] = '{4'd9, 32'hFFFF_FFFF, 4'hF, 4'd9, 32'h0000_0000, 32'h11BB_FFDD};
        vecs[14] = '{4'd15, 32'hFFFF_FFFF, 4'hF, 4'd15, 32'h0000_0000, 32'h11BB_FFDD};

        idle();
        resetn = 1'b0; gpio_in = '0; gpio_in8 = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        chk("rst_oe", gpio_oe, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_out", gpio_out, 32'h0);
        for (int i = 0; i < 16; i++) rd(1'b0, 4'(i), 32'h0, $sformatf("rst_rd%0d", i));

        for (int i = 0; i < 15; i++) begin
            wr(1'b0, vecs[i].off, vecs[i].wdata, vecs[i].wmask);
            rd(1'b0, vecs[i].roff, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
            chk($sformatf("vec%0d_out", i), gpio_out, vecs[i].exp_out);
        end
        chk("dir_oe", gpio_oe, 32'h0000_FFFF);

        // Read and write of OUT in the same cycle: old value returned.
        sel = 1'b1; mem_rstrb = 1'b1; mem_wordoff = 4'd0;
        mem_wdata = 32'h0000_00A5; mem_wmask = 4'hF;
        sbq.push_back('{32'h11BB_FFDD, 1'b0, "rw_same_cycle"});
        @(negedge clk);
        idle();
        rd(1'b0, 4'd0, 32'h0000_00A5, "rw_after");

        // Sync latency on pin 3 (RISE_EN[3]=1).
        gpio_in[3] = 1'b1;
        @(negedge clk);
        rd(1'b0, 4'd2, 32'h0, "in_edge1");
        chk("irq_edge1", 32'(irq), 32'h0);
        rd(1'b0, 4'd2, 32'h8, "in_edge2");
        chk("irq_edge2", 32'(irq), 32'h1);

        gpio_in[7] = 1'b1;
        @(negedge clk);
        gpio_in[7] = 1'b0;
        repeat (5) @(negedge clk);
        rd(1'b0, 4'd8, 32'h8, "status_noen");
        wr(1'b0, 4'd8, 32'h8, 4'hF);
        chk("irq_w1c3", 32'(irq), 32'h0);
        rd(1'b0, 4'd8, 32'h0, "status_w1c3");

        // Falling edges on pin 5 with FALL_EN[5]=1.
        gpio_in[5] = 1'b1;
        repeat (4) @(negedge clk);
        gpio_in[5] = 1'b0;
        repeat (4) @(negedge clk);
        chk("irq_fall5", 32'(irq), 32'h1);
        gpio_in[5] = 1'b1;
        repeat (4) @(negedge clk);
        gpio_in[5] = 1'b0;
        repeat (2) @(negedge clk);
        wr(1'b0, 4'd8, 32'h20, 4'hF);
        chk("irq_collide", 32'(irq), 32'h1);
        rd(1'b0, 4'd8, 32'h20, "status_collide");
        wr(1'b0, 4'd8, 32'h20, 4'hF);
        chk("irq_quiet_w1c", 32'(irq), 32'h0);
        rd(1'b0, 4'd8, 32'h0, "status_quiet_w1c");

        // Pending bit survives enable clear; then async reset mid-operation.
        gpio_in[3] = 1'b0;
        repeat (4) @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (4) @(negedge clk);
        wr(1'b0, 4'd6, 32'h0, 4'hF);
        rd(1'b0, 4'd8, 32'h8, "status_en_cleared");
        wr(1'b0, 4'd1, 32'hFFFF_FFFF, 4'hF);
        chk("oe_all", gpio_oe, 32'hFFFF_FFFF);
        chk("irq_pre_rst", 32'(irq), 32'h1);
        #1 resetn = 1'b0;
        #1;
        chk("async_oe", gpio_oe, 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_out", gpio_out, 32'h0);
        #1 resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("irq_post_rst", 32'(irq), 32'h0);
        rd(1'b0, 4'd8, 32'h0, "status_post_rst");
        rd(1'b0, 4'd1, 32'h0, "dir_post_rst");
        rd(1'b0, 4'd2, 32'h8, "in_post_rst");

        // NPINS=8 instance: upper bits read 0.
        wr(1'b1, 4'd0, 32'hFFFF_FFFF, 4'hF);
        rd(1'b1, 4'd0, 32'h0000_00FF, "n8_out_rd");
        chk("n8_gpio_out", 32'(out8), 32'h0000_00FF);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
